// File: rtl/pe_array_ctrl_if.sv
// Handshake/control bundle between a job issuer (master) and pe_array_ctrl (slave).
interface pe_array_ctrl_if #(
  parameter int unsigned ARRAY_SIZE = 4,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned ADDR_W     = 8
) ();

  logic                  start_i;
  logic                  abort_i;
  logic [LEN_W-1:0]      cfg_len_i;
  logic                  weight_en_o;
  logic [ADDR_W-1:0]     w_addr_o;
  logic [ARRAY_SIZE-1:0] ifmap_en_o;
  logic [ADDR_W-1:0]     x_addr_o;
  logic                  psum_en_o;
  logic                  busy_o;
  logic                  done_o;
  logic [31:0]           cycle_cnt_o;

  modport master (
    output start_i, abort_i, cfg_len_i,
    input  weight_en_o, w_addr_o, ifmap_en_o, x_addr_o, psum_en_o, busy_o, done_o, cycle_cnt_o
  );

  modport slave (
    input  start_i, abort_i, cfg_len_i,
    output weight_en_o, w_addr_o, ifmap_en_o, x_addr_o, psum_en_o, busy_o, done_o, cycle_cnt_o
  );

endinterface

// File: rtl/pe_array_ctrl.sv
// Job sequencer for an NxN systolic PE array: weight load, skewed ifmap stream, psum drain.
// Optional job cycle counter enabled by defining PE_ARRAY_CTRL_PERF_CNT_EN.
module pe_array_ctrl #(
  parameter int unsigned ARRAY_SIZE = 4,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pe_array_ctrl_if.slave    bus
);

  localparam int unsigned DlyLen = 2 * ARRAY_SIZE;
  localparam int unsigned DlyCntW = $clog2(DlyLen) + 1;
  localparam int unsigned CntW = (LEN_W > DlyCntW) ? LEN_W : DlyCntW;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoadW  = 3'd1;
  localparam logic [2:0] StStream = 3'd2;
  localparam logic [2:0] StDrain  = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]     w_addr_q, w_addr_d;
  logic [ADDR_W-1:0]     x_addr_q, x_addr_d;
  logic [DlyLen-1:0]     dly_q, dly_d;
  logic                  stream_v;
  logic [ARRAY_SIZE-1:0] ifmap_en;

  assign stream_v = (state_q == StStream);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    w_addr_d = w_addr_q;
    x_addr_d = x_addr_q;
    dly_d    = {dly_q[DlyLen-2:0], stream_v};
    if (bus.abort_i) begin
      state_d  = StIdle;
      cnt_d    = '0;
      w_addr_d = '0;
      x_addr_d = '0;
      dly_d    = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start_i) begin
            len_d   = bus.cfg_len_i;
            cnt_d   = '0;
            state_d = (bus.cfg_len_i != '0) ? StLoadW : StDone;
          end
        end
        // Addresses advance only while staying in the phase, so they hold the last
        // issued address afterwards.
        StLoadW: begin
          if (cnt_q == CntW'(ARRAY_SIZE - 1)) begin
            state_d = StStream;
            cnt_d   = '0;
          end else begin
            cnt_d    = cnt_q + CntW'(1);
            w_addr_d = w_addr_q + ADDR_W'(1);
          end
        end
        StStream: begin
          if (cnt_q == CntW'(len_q) - CntW'(1)) begin
            state_d = StDrain;
            cnt_d   = '0;
          end else begin
            cnt_d    = cnt_q + CntW'(1);
            x_addr_d = x_addr_q + ADDR_W'(1);
          end
        end
        StDrain: begin
          if (cnt_q == CntW'(DlyLen - 1)) begin
            state_d = StDone;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDone: begin
          state_d  = StIdle;
          w_addr_d = '0;
          x_addr_d = '0;
        end
        default: begin
          state_d  = StIdle;
          cnt_d    = '0;
          w_addr_d = '0;
          x_addr_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      len_q    <= '0;
      cnt_q    <= '0;
      w_addr_q <= '0;
      x_addr_q <= '0;
      dly_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      w_addr_q <= w_addr_d;
      x_addr_q <= x_addr_d;
      dly_q    <= dly_d;
    end
  end

  // Row r sees the stream r cycles late; row 0 is the live stream_v.
  for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_skew
    if (r == 0) begin : g_row0
      assign ifmap_en[r] = stream_v;
    end else begin : g_rown
      assign ifmap_en[r] = dly_q[r-1];
    end
  end

  assign bus.weight_en_o = (state_q == StLoadW);
  assign bus.w_addr_o    = w_addr_q;
  assign bus.ifmap_en_o  = ifmap_en;
  assign bus.x_addr_o    = x_addr_q;
  assign bus.psum_en_o   = dly_q[DlyLen-1];
  assign bus.busy_o      = (state_q != StIdle);
  assign bus.done_o      = (state_q == StDone);

`ifdef PE_ARRAY_CTRL_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == StIdle && bus.start_i && !bus.abort_i) begin
      cyc_d = '0;
    end else if (state_q != StIdle) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign bus.cycle_cnt_o = cyc_q;
`else
  assign bus.cycle_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Bench for pe_array_ctrl: directed job scenarios plus random traffic, two instances
// (ADDR_W=8 and ADDR_W=2) checked against a per-job timing model.
module tb_pe_array_ctrl;

  localparam int N = 4;
`ifdef PE_ARRAY_CTRL_PERF_CNT_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  logic clk;
  logic rst_n;

  pe_array_ctrl_if #(.ARRAY_SIZE(N), .LEN_W(8), .ADDR_W(8)) bus_a ();
  pe_array_ctrl_if #(.ARRAY_SIZE(N), .LEN_W(8), .ADDR_W(2)) bus_b ();

  pe_array_ctrl #(.ARRAY_SIZE(N), .LEN_W(8), .ADDR_W(8)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  pe_array_ctrl #(.ARRAY_SIZE(N), .LEN_W(8), .ADDR_W(2)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Job model: active flag, cycle index within job (1 = first cycle after acceptance),
  // latched length, and the cycle count held while idle.
  bit m_act;
  int m_t;
  int m_len;
  int m_hold;

  int scen_cyc;
  int done_cnt;
  int last_done_cyc;
  int busy_cnt;
  int x_seq[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int done_t_of(input int len);
    return (len == 0) ? 1 : 3 * N + len + 1;
  endfunction

  task automatic check_dut(input string p, input int amask, input logic we,
                           input logic [7:0] wa, input logic [3:0] ie, input logic [7:0] xa,
                           input logic pe, input logic bz, input logic dn,
                           input logic [31:0] cc);
    logic       e_we, e_pe, e_bz, e_dn;
    logic [7:0] e_wa, e_xa;
    logic [3:0] e_ie;
    int         e_cc;
    int         s0, s1;
    e_we = 0; e_pe = 0; e_bz = 0; e_dn = 0;
    e_wa = 0; e_xa = 0; e_ie = 0;
    e_cc = m_hold;
    if (m_act) begin
      e_bz = 1;
      e_cc = m_t - 1;
      e_dn = (m_t == done_t_of(m_len));
      if (m_len != 0) begin
        s0   = N + 1;
        s1   = N + m_len;
        e_we = (m_t <= N);
        e_wa = 8'(((m_t <= N) ? m_t - 1 : N - 1) & amask);
        if (m_t <= N) e_xa = 0;
        else if (m_t <= s1) e_xa = 8'((m_t - s0) & amask);
        else e_xa = 8'((m_len - 1) & amask);
        for (int r = 0; r < N; r++) e_ie[r] = (m_t >= s0 + r) && (m_t <= s1 + r);
        e_pe = (m_t >= s0 + 2 * N) && (m_t <= s1 + 2 * N);
      end
    end
    if (!Perf) e_cc = 0;
    check_val({p, "_weight_en"}, 32'(we), 32'(e_we));
    check_val({p, "_w_addr"}, 32'(wa), 32'(e_wa));
    check_val({p, "_ifmap_en"}, 32'(ie), 32'(e_ie));
    check_val({p, "_x_addr"}, 32'(xa), 32'(e_xa));
    check_val({p, "_psum_en"}, 32'(pe), 32'(e_pe));
    check_val({p, "_busy"}, 32'(bz), 32'(e_bz));
    check_val({p, "_done"}, 32'(dn), 32'(e_dn));
    check_val({p, "_cycle_cnt"}, cc, 32'(e_cc));
  endtask

  task automatic scen_reset();
    scen_cyc      = 0;
    done_cnt      = 0;
    last_done_cyc = -1;
    busy_cnt      = 0;
    x_seq.delete();
  endtask

  // One clock cycle: drive inputs, check both DUTs mid-cycle, then advance the model.
  task automatic step(input logic st, input logic ab, input logic rn, input logic [7:0] ln);
    bus_a.start_i   = st;
    bus_a.abort_i   = ab;
    bus_a.cfg_len_i = ln;
    bus_b.start_i   = st;
    bus_b.abort_i   = ab;
    bus_b.cfg_len_i = ln;
    rst_n           = rn;
    @(negedge clk);
    check_dut("a", 8'hff, bus_a.weight_en_o, bus_a.w_addr_o, bus_a.ifmap_en_o,
              bus_a.x_addr_o, bus_a.psum_en_o, bus_a.busy_o, bus_a.done_o, bus_a.cycle_cnt_o);
    check_dut("b", 3, bus_b.weight_en_o, {6'd0, bus_b.w_addr_o}, bus_b.ifmap_en_o,
              {6'd0, bus_b.x_addr_o}, bus_b.psum_en_o, bus_b.busy_o, bus_b.done_o,
              bus_b.cycle_cnt_o);
    if (bus_a.done_o) begin
      done_cnt++;
      last_done_cyc = scen_cyc;
    end
    if (bus_a.busy_o) busy_cnt++;
    if (bus_b.ifmap_en_o[0]) x_seq.push_back(int'(bus_b.x_addr_o));
    @(posedge clk);
    if (!rn) begin
      m_act  = 0;
      m_hold = 0;
    end else if (ab) begin
      if (m_act) m_hold = m_t;
      m_act = 0;
    end else if (m_act) begin
      m_t++;
      if (m_t > done_t_of(m_len)) begin
        m_act  = 0;
        m_hold = done_t_of(m_len);
      end
    end else if (st) begin
      m_act = 1;
      m_t   = 1;
      m_len = int'(ln);
    end
    scen_cyc++;
    #1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 8'(i * 37));
  endtask

  initial begin
    int exp_x[6];
    m_act  = 0;
    m_t    = 0;
    m_len  = 0;
    m_hold = 0;
    bus_a.start_i = 0; bus_a.abort_i = 0; bus_a.cfg_len_i = 0;
    bus_b.start_i = 0; bus_b.abort_i = 0; bus_b.cfg_len_i = 0;
    rst_n = 0;
    @(posedge clk);
    #1;
    scen_reset();
    step(0, 0, 0, 0);
    idle_n(2);

    // Nominal job, len 3; cfg_len wiggles mid-job must not matter.
    scen_reset();
    step(1, 0, 1, 3);
    idle_n(20);
    check_val("nom_done_cyc", last_done_cyc, 16);
    check_val("nom_done_cnt", done_cnt, 1);
    check_val("nom_cycle_cnt", bus_a.cycle_cnt_o, Perf ? 16 : 0);

    // Zero-length job.
    scen_reset();
    step(1, 0, 1, 0);
    idle_n(4);
    check_val("zero_done_cyc", last_done_cyc, 1);
    check_val("zero_busy_cycles", busy_cnt, 1);

    // Abort on cycle 6, restart requested on cycle 7.
    scen_reset();
    step(1, 0, 1, 3);
    idle_n(5);
    step(0, 1, 1, 3);
    step(1, 0, 1, 3);
    check_val("abort_restart_busy", bus_a.busy_o, 1);
    check_val("abort_done_cnt", done_cnt, 0);
    idle_n(20);

    // Spurious start on cycle 9.
    scen_reset();
    step(1, 0, 1, 3);
    idle_n(8);
    step(1, 0, 1, 9);
    idle_n(10);
    check_val("ign_done_cyc", last_done_cyc, 16);

    // Reset on cycle 10.
    scen_reset();
    step(1, 0, 1, 3);
    idle_n(9);
    step(0, 0, 0, 3);
    idle_n(8);
    check_val("rst_done_cnt", done_cnt, 0);

    // Abort and start together in IDLE: abort wins.
    scen_reset();
    step(1, 1, 1, 5);
    idle_n(2);
    check_val("abort_start_busy_cycles", busy_cnt, 0);

    // Narrow address wrap on instance b.
    scen_reset();
    step(1, 0, 1, 6);
    idle_n(24);
    exp_x = '{0, 1, 2, 3, 0, 1};
    check_val("wrap_len", x_seq.size(), 6);
    for (int i = 0; i < 6 && i < x_seq.size(); i++) check_val("wrap_x_addr", x_seq[i], exp_x[i]);

    // Random traffic.
    scen_reset();
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 255) != 0), 8'($urandom_range(0, 12)));
    end
    idle_n(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pe_array_ctrl.md
PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
REQ-001 The module SHALL provide parameter ARRAY_SIZE, default 4, meaning the PE rows/columns of the square systolic array (N).
REQ-002 The module SHALL provide parameter LEN_W, default 8, meaning the width of the job-length field.
REQ-003 The module SHALL provide parameter ADDR_W, default 8, meaning the buffer read-address width.
REQ-004 The module SHALL provide port clk, input, 1 bit, the single clock with all logic on its rising edge.
REQ-005 The module SHALL provide port rst_n, input, 1 bit, a synchronous active-low reset.
REQ-006 The module SHALL provide port start_i, input, 1 bit, a job request sampled only in IDLE.
REQ-007 The module SHALL provide port abort_i, input, 1 bit, a synchronous job cancel.
REQ-008 The module SHALL provide port cfg_len_i, input, LEN_W bits, the number of ifmap vectors, sampled with start_i.
REQ-009 The module SHALL provide port weight_en_o, output, 1 bit, the weight-register load enable for the array.
REQ-010 The module SHALL provide port w_addr_o, output, ADDR_W bits, the weight-buffer read address.
REQ-011 The module SHALL provide port ifmap_en_o, output, ARRAY_SIZE bits, the row-skewed ifmap enables.
REQ-012 The module SHALL provide port x_addr_o, output, ADDR_W bits, the ifmap-buffer read address.
REQ-013 The module SHALL provide port psum_en_o, output, 1 bit, the psum-capture enable (result valid).
REQ-014 The module SHALL provide port busy_o, output, 1 bit, high whenever the state is not IDLE.
REQ-015 The module SHALL provide port done_o, output, 1 bit, a one-cycle job-complete pulse.
REQ-016 The module SHALL provide port cycle_cnt_o, output, 32 bits, the job cycle count (see Configuration).

Function
REQ-017 The FSM SHALL have exactly the states IDLE, LOAD_W, STREAM, DRAIN and DONE.
REQ-018 IDLE SHALL go to LOAD_W on start_i=1 when cfg_len_i!=0, and to DONE on start_i=1 when cfg_len_i==0, in which case no enable is ever asserted.
REQ-019 LOAD_W SHALL last exactly N cycles, with weight_en_o=1 and w_addr_o stepping 0..N-1 by one per cycle.
REQ-020 STREAM SHALL last exactly the latched cfg_len cycles, with internal stream_v=1 and x_addr_o stepping 0..len-1 by one per cycle.
REQ-021 ifmap_en_o[r] SHALL equal stream_v delayed by r cycles, so that ifmap_en_o[0] is unregistered relative to stream_v.
REQ-022 psum_en_o SHALL equal stream_v delayed by 2N cycles.
REQ-023 DRAIN SHALL last exactly 2N cycles, so that the last psum_en_o pulse occurs in the final DRAIN cycle.
REQ-024 DONE SHALL last one cycle with done_o=1 and then go to IDLE.
REQ-025 When the state is not IDLE, w_addr_o and x_addr_o SHALL hold their last values outside their active states, and they SHALL be cleared to 0 on entry to IDLE.
REQ-026 start_i asserted in any non-IDLE state SHALL be ignored, and cfg_len_i changes during a job SHALL have no effect.
REQ-027 The address counters SHALL wrap modulo 2^ADDR_W.
REQ-028 abort_i=1 in any state SHALL force IDLE on the next edge, clear all delay lines, deassert all enables, and produce no done_o.
REQ-029 When abort_i and start_i are high in the same cycle, abort_i SHALL have priority.
REQ-030 A start_i arriving in the cycle the FSM returns to IDLE SHALL be accepted one cycle later, so that jobs are not chained.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force state IDLE, clear the latched length, the counters, the delay lines and cycle_cnt_o, and drive every output to 0.
REQ-032 A reset applied mid-job SHALL abandon the job with no done_o pulse.

Configuration
REQ-033 When macro PE_ARRAY_CTRL_PERF_CNT_EN is defined, cycle_cnt_o SHALL count busy_o cycles of the current job, clear on job acceptance, and hold its value after DONE or abort.
REQ-034 When PE_ARRAY_CTRL_PERF_CNT_EN is undefined, cycle_cnt_o SHALL be tied to 0 and no counter logic SHALL be instantiated.

Verification
REQ-035 The bench SHALL cover: N=4, start at edge 0 with cfg_len=3 -> weight_en_o high on cycles 1-4 (w_addr 0..3), ifmap_en_o[0] high on cycles 5-7, ifmap_en_o[3] high on cycles 8-10, psum_en_o high on cycles 13-15, done_o on cycle 16, cycle_cnt_o=16.
REQ-036 The bench SHALL cover: cfg_len=0 -> done_o on cycle 1, busy_o high for 1 cycle, and no weight/ifmap/psum enables.
REQ-037 The bench SHALL cover: abort_i on cycle 6 of a cfg_len=3 job -> all outputs 0 from cycle 7, no done_o, and a new start is accepted on cycle 8.
REQ-038 The bench SHALL cover: start_i pulsed on cycle 9 of an active job -> ignored, with timing identical to REQ-035.
REQ-039 The bench SHALL cover: rst_n=0 on cycle 10 of a job -> all outputs 0 on the following cycle and no done_o.
REQ-040 The bench SHALL cover: ADDR_W=2 with cfg_len=6 -> x_addr_o sequence 0,1,2,3,0,1.
